user_ip_apb_arb2: RTL and testbench

//  Two-master APB4 arbiter that lets two requesters share one user-IP APB4 slave port.

---
 rtl/user_ip_apb_arb2_pkg.sv | 28 ++
 rtl/user_ip_apb_arb2_if.sv | 26 ++
 rtl/user_ip_apb_arb2_rr.sv | 20 ++
 rtl/user_ip_apb_arb2.sv | 111 +++++++++++
 tb/tb_user_ip_apb_arb2.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/user_ip_apb_arb2_pkg.sv
// Shared types and widths for the two-master APB4 arbiter slice.
package user_ip_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned TMO_W  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } arb_state_e;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    // Request-side payload forwarded from the granted master to the slave.
    typedef struct packed {
        logic [ADDR_W-1:0] paddr;
        logic              pwrite;
        logic [DATA_W-1:0] pwdata;
        logic [STRB_W-1:0] pstrb;
        logic [PROT_W-1:0] pprot;
    } apb_req_t;

endpackage

// File: rtl/user_ip_apb_arb2_if.sv
// APB4 bus bundle; master modport drives the request, slave modport drives the response.
interface apb4_if;
    import user_ip_arb_pkg::*;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [PROT_W-1:0] pprot;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/user_ip_apb_arb2_rr.sv
// Two-requester grant picker: round-robin against the last-served pointer, or fixed m0 priority.
module user_ip_rr_arb2
    import user_ip_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       prio_mode,
    output logic       grant
);

    always_comb begin
        grant = GRANT_M0;
        if (req == 2'b10) begin
            grant = GRANT_M1;
        end else if (req == 2'b11) begin
            grant = prio_mode ? GRANT_M0 : ~last;
        end
    end

endmodule

// File: rtl/user_ip_apb_arb2.sv
// Two-master APB4 arbiter: serialises whole transfers from m0/m1 onto one user-IP slave port,
// with an optional access-phase timeout that completes the transfer with an error.
module user_ip_apb_arb2
    import user_ip_arb_pkg::*;
#(
    parameter int unsigned PRIO_MODE   = 0,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    apb4_if.slave  m0,
    apb4_if.slave  m1,
    apb4_if.master s,
    output logic   busy_o
);

    localparam bit               TMO_EN  = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    arb_state_e       state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             pick;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             tmo_hit, done;
    logic             s_psel, s_penable;
    apb_req_t         req_m0, req_m1, req_sel;

    user_ip_rr_arb2 u_pick (
        .req       ({m1.psel, m0.psel}),
        .last      (last_q),
        .prio_mode (PRIO_MODE != 0),
        .grant     (pick)
    );

    // A ready slave always beats a coinciding timeout.
    assign tmo_hit = TMO_EN && (state_q == ARB_ACCESS) && !s.pready && (cnt_q == TMO_LIM);
    assign done    = (state_q == ARB_ACCESS) && (s.pready || tmo_hit);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            grant_q <= GRANT_M0;
            last_q  <= GRANT_M1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        s_psel    = 1'b0;
        s_penable = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (m0.psel || m1.psel) begin
                    grant_d = pick;
                    state_d = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                s_psel  = 1'b1;
                cnt_d   = '0;
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                s_psel    = !tmo_hit;
                s_penable = !tmo_hit;
                if (done) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign req_m0 = '{paddr: m0.paddr, pwrite: m0.pwrite, pwdata: m0.pwdata,
                      pstrb: m0.pstrb, pprot: m0.pprot};
    assign req_m1 = '{paddr: m1.paddr, pwrite: m1.pwrite, pwdata: m1.pwdata,
                      pstrb: m1.pstrb, pprot: m1.pprot};
    assign req_sel = (grant_q == GRANT_M1) ? req_m1 : req_m0;

    assign s.psel    = s_psel;
    assign s.penable = s_penable;
    assign s.paddr   = req_sel.paddr;
    assign s.pwrite  = req_sel.pwrite;
    assign s.pwdata  = req_sel.pwdata;
    assign s.pstrb   = req_sel.pstrb;
    assign s.pprot   = req_sel.pprot;

    // Responses reach only the granted master; a timeout returns an error with no data.
    assign m0.pready  = done && (grant_q == GRANT_M0);
    assign m0.prdata  = (done && !tmo_hit && (grant_q == GRANT_M0)) ? s.prdata : '0;
    assign m0.pslverr = done && (grant_q == GRANT_M0) && (tmo_hit || s.pslverr);
    assign m1.pready  = done && (grant_q == GRANT_M1);
    assign m1.prdata  = (done && !tmo_hit && (grant_q == GRANT_M1)) ? s.prdata : '0;
    assign m1.pslverr = done && (grant_q == GRANT_M1) && (tmo_hit || s.pslverr);

    assign busy_o = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_user_ip_apb_arb2.sv
// Directed self-checking bench: instance A is round-robin with a 4-cycle timeout,
// instance B is fixed priority with no timeout.
module tb_user_ip_apb_arb2;

    logic clk;
    logic rst_n;
    logic a_busy, b_busy;
    int   n_cmp;
    int   n_err;

    apb4_if a_m0 ();
    apb4_if a_m1 ();
    apb4_if a_s  ();
    apb4_if b_m0 ();
    apb4_if b_m1 ();
    apb4_if b_s  ();

    user_ip_apb_arb2 #(.PRIO_MODE(0), .TIMEOUT_CYC(4)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m0      (a_m0.slave),
        .m1      (a_m1.slave),
        .s       (a_s.master),
        .busy_o  (a_busy)
    );

    user_ip_apb_arb2 #(.PRIO_MODE(1), .TIMEOUT_CYC(0)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .m0      (b_m0.slave),
        .m1      (b_m1.slave),
        .s       (b_s.master),
        .busy_o  (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_m0.psel = 0; a_m0.penable = 0; a_m0.pwrite = 0; a_m0.paddr = '0;
        a_m0.pwdata = '0; a_m0.pstrb = '0; a_m0.pprot = '0;
        a_m1.psel = 0; a_m1.penable = 0; a_m1.pwrite = 0; a_m1.paddr = '0;
        a_m1.pwdata = '0; a_m1.pstrb = '0; a_m1.pprot = '0;
        b_m0.psel = 0; b_m0.penable = 0; b_m0.pwrite = 0; b_m0.paddr = '0;
        b_m0.pwdata = '0; b_m0.pstrb = '0; b_m0.pprot = '0;
        b_m1.psel = 0; b_m1.penable = 0; b_m1.pwrite = 0; b_m1.paddr = '0;
        b_m1.pwdata = '0; b_m1.pstrb = '0; b_m1.pprot = '0;
        a_s.pready = 0; a_s.prdata = '0; a_s.pslverr = 0;
        b_s.pready = 0; b_s.prdata = '0; b_s.pslverr = 0;

        // Reset state
        tick(); tick();
        chk1("rst_s_psel", a_s.psel, 1'b0);
        chk1("rst_s_penable", a_s.penable, 1'b0);
        chk1("rst_m0_pready", a_m0.pready, 1'b0);
        chk32("rst_m0_prdata", a_m0.prdata, 32'h0);
        chk1("rst_m1_pslverr", a_m1.pslverr, 1'b0);
        chk1("rst_busy_a", a_busy, 1'b0);
        chk1("rst_busy_b", b_busy, 1'b0);
        rst_n = 1'b1;

        // Test 1: m0 read, zero-wait slave returning 0xFF
        tick();
        a_m0.psel = 1; a_m0.paddr = 32'h0; a_m0.pwrite = 0;
        a_s.pready = 1; a_s.prdata = 32'hFF;
        #1;
        chk1("t1_c0_s_psel", a_s.psel, 1'b0);
        tick();
        a_m0.penable = 1;
        #1;
        chk1("t1_c1_s_psel", a_s.psel, 1'b1);
        chk1("t1_c1_s_penable", a_s.penable, 1'b0);
        chk1("t1_c1_m0_pready", a_m0.pready, 1'b0);
        tick();
        chk1("t1_c2_s_penable", a_s.penable, 1'b1);
        chk1("t1_c2_m0_pready", a_m0.pready, 1'b1);
        chk32("t1_c2_m0_prdata", a_m0.prdata, 32'hFF);
        chk1("t1_c2_m1_pready", a_m1.pready, 1'b0);
        tick();
        a_m0.psel = 0; a_m0.penable = 0;
        #1;
        chk1("t1_c3_busy", a_busy, 1'b0);
        chk32("t1_c3_m0_prdata", a_m0.prdata, 32'h0);

        // Test 2: simultaneous writes after reset, round-robin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        a_m0.psel = 1; a_m0.pwrite = 1; a_m0.paddr = 32'h10; a_m0.pwdata = 32'h11;
        a_m1.psel = 1; a_m1.pwrite = 1; a_m1.paddr = 32'h20; a_m1.pwdata = 32'h22;
        a_s.pready = 1;
        tick();
        chk32("t2_first_paddr", a_s.paddr, 32'h10);
        chk32("t2_first_pwdata", a_s.pwdata, 32'h11);
        tick();
        chk1("t2_m0_done", a_m0.pready, 1'b1);
        chk1("t2_m1_stall", a_m1.pready, 1'b0);
        tick();
        a_m0.psel = 0;
        #1;
        chk1("t2_gap_busy", a_busy, 1'b0);
        tick();
        chk1("t2_second_psel", a_s.psel, 1'b1);
        chk32("t2_second_paddr", a_s.paddr, 32'h20);
        tick();
        chk1("t2_m1_done", a_m1.pready, 1'b1);
        chk1("t2_m0_idle", a_m0.pready, 1'b0);
        tick();
        a_m0.psel = 1;
        tick();
        chk32("t2_retie_paddr", a_s.paddr, 32'h10);
        tick();
        chk1("t2_retie_m0_done", a_m0.pready, 1'b1);
        chk1("t2_retie_m1_stall", a_m1.pready, 1'b0);
        tick();
        a_m0.psel = 0; a_m1.psel = 0;
        a_s.pready = 0;

        // Test 4: m1 write with three slave wait states
        tick();
        a_m1.psel = 1; a_m1.pwrite = 1; a_m1.paddr = 32'h40;
        a_m1.pwdata = 32'hDEAD_BEEF; a_m1.pstrb = 4'hF;
        tick();
        chk32("t4_setup_pwdata", a_s.pwdata, 32'hDEAD_BEEF);
        chk32("t4_setup_pstrb", 32'(a_s.pstrb), 32'hF);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk1("t4_wait_penable", a_s.penable, 1'b1);
            chk1("t4_wait_m1_pready", a_m1.pready, 1'b0);
            chk32("t4_wait_pwdata", a_s.pwdata, 32'hDEAD_BEEF);
            chk32("t4_wait_pstrb", 32'(a_s.pstrb), 32'hF);
        end
        tick();
        a_s.pready = 1;
        #1;
        chk1("t4_c5_m1_pready", a_m1.pready, 1'b1);
        chk32("t4_c5_pwdata", a_s.pwdata, 32'hDEAD_BEEF);
        tick();
        a_m1.psel = 0; a_m1.pstrb = 4'h0;
        a_s.pready = 0;

        // Test 5: slave never ready, 4-cycle timeout
        tick();
        a_m0.psel = 1; a_m0.pwrite = 0; a_m0.paddr = 32'h30;
        a_s.prdata = 32'h1234_5678; a_s.pslverr = 0;
        tick();
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk1("t5_wait_s_psel", a_s.psel, 1'b1);
            chk1("t5_wait_m0_pready", a_m0.pready, 1'b0);
        end
        tick();
        chk1("t5_tmo_pready", a_m0.pready, 1'b1);
        chk1("t5_tmo_pslverr", a_m0.pslverr, 1'b1);
        chk32("t5_tmo_prdata", a_m0.prdata, 32'h0);
        chk1("t5_tmo_s_psel", a_s.psel, 1'b0);
        tick();
        a_m0.psel = 0;
        #1;
        chk1("t5_next_s_psel", a_s.psel, 1'b0);
        chk1("t5_next_busy", a_busy, 1'b0);

        // Test 6: reset asserted during ACCESS
        tick();
        a_m0.psel = 1; a_m0.paddr = 32'h50;
        tick();
        tick();
        chk1("t6_access_penable", a_s.penable, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_s_psel", a_s.psel, 1'b0);
        chk1("t6_rst_s_penable", a_s.penable, 1'b0);
        chk1("t6_rst_busy", a_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        a_m1.psel = 1; a_m1.paddr = 32'h60;
        tick();
        chk1("t6_post_s_psel", a_s.psel, 1'b1);
        chk32("t6_post_paddr", a_s.paddr, 32'h50);
        tick();
        a_s.pready = 1;
        #1;
        chk1("t6_post_m0_pready", a_m0.pready, 1'b1);
        chk1("t6_post_m1_pready", a_m1.pready, 1'b0);
        tick();
        a_m0.psel = 0; a_m1.psel = 0; a_s.pready = 0;

        // Test 3: fixed priority, m0 re-requests every IDLE while m1 waits
        tick();
        b_m0.psel = 1; b_m0.paddr = 32'h100;
        b_m1.psel = 1; b_m1.paddr = 32'h200;
        b_s.pready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("t3_idle_s_psel", b_s.psel, 1'b0);
            tick();
            chk32("t3_m0_paddr", b_s.paddr, 32'h100);
            tick();
            chk1("t3_m0_pready", b_m0.pready, 1'b1);
            chk1("t3_m1_stall", b_m1.pready, 1'b0);
            tick();
        end
        b_m0.psel = 0;
        tick();
        chk32("t3_m1_paddr", b_s.paddr, 32'h200);
        tick();
        chk1("t3_m1_pready", b_m1.pready, 1'b1);
        chk1("t3_m0_idle", b_m0.pready, 1'b0);
        tick();
        b_m1.psel = 0; b_s.pready = 0;
        #1;
        chk1("t3_end_busy", b_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
